// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    localparam logic [6:0] HEX_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment code lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] code_o
);

    always_comb begin
        code_o = HEX_CODE[nibble_i];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver with frame-synchronous double buffering,
// leading-zero blanking and per-digit decimal points. All pins are registered.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] disp_data,
    input  logic        disp_valid,
    input  logic        lz_blank,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an_o,
    output logic [7:0]  seg_o,
    output logic        frame_done
);

    localparam int unsigned PW        = $clog2(SCAN_DIV + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam digit_idx_t LAST_IDX   = digit_idx_t'(NUM_DIGITS - 1);

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    logic [31:0]   pending_q, pending_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          tick;
    logic          frame_edge;
    logic [3:0]    cur_nibble;
    logic [6:0]    cur_code;
    logic [7:0]    nz_above;
    logic          blank;

    always_comb begin
        tick       = (presc_q == PRESC_MAX);
        presc_d    = tick ? '0 : presc_q + 1'b1;
        idx_d      = tick ? idx_q + 1'b1 : idx_q;
        frame_edge = tick && (idx_q == LAST_IDX);

        pending_d = disp_valid ? disp_data : pending_q;
        // A word arriving on the boundary cycle itself goes straight to the display.
        shadow_d  = frame_edge ? (disp_valid ? disp_data : pending_q) : shadow_q;

        frame_done_d = frame_edge;
    end

    // nz_above[k]: some nibble at position k or higher is non-zero.
    always_comb begin
        nz_above    = '0;
        nz_above[7] = |shadow_q[31:28];
        for (int k = 6; k >= 0; k--) begin
            nz_above[k] = nz_above[k+1] | (|shadow_q[4*k +: 4]);
        end
    end

    always_comb begin
        cur_nibble = shadow_q[4*idx_q +: 4];
        blank      = lz_blank && (idx_q != '0) && !nz_above[idx_q];
        an_d       = ~(8'b1 << idx_q);
        seg_d      = blank ? SEG_BLANK : {~dp_mask[idx_q], cur_code};
    end

    seg7_hex_decode u_hex_decode (
        .nibble_i (cur_nibble),
        .code_o   (cur_code)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            shadow_q     <= '0;
            frame_done_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an_o       = an_q;
    assign seg_o      = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a SCAN_DIV=4 instance for scanning, buffering,
// blanking and decimal points, and a SCAN_DIV=1 instance for the every-cycle rotation.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rstn;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        lz_blank;
    logic [7:0]  dp_mask;

    logic [7:0]  an4, seg4, an1, seg1;
    logic        fd4, fd1;

    int checks;
    int failures;
    int cyc;

    seg7_scan_driver #(.SCAN_DIV(4)) dut4 (
        .clk        (clk),
        .rstn       (rstn),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .lz_blank   (lz_blank),
        .dp_mask    (dp_mask),
        .an_o       (an4),
        .seg_o      (seg4),
        .frame_done (fd4)
    );

    seg7_scan_driver #(.SCAN_DIV(1)) dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .lz_blank   (lz_blank),
        .dp_mask    (dp_mask),
        .an_o       (an1),
        .seg_o      (seg1),
        .frame_done (fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic pulse(input logic [31:0] d);
        disp_data  = d;
        disp_valid = 1'b1;
        step();
        disp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        disp_data  = 32'h1234_5678;
        disp_valid = 1'b1;
        lz_blank   = 1'b0;
        dp_mask    = 8'h00;
        rstn       = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("reset_an", an4, 8'hFF);
        chk("reset_seg", seg4, 8'hFF);
        chk("reset_fd", fd4, 1'b0);

        // Run a loaded frame, then reset mid-run on the frame_done cycle.
        @(posedge clk);
        #1 rstn = 1'b1;
        cyc = 0;
        step_to(32);
        chk("pre_fd", fd4, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("midreset_an", an4, 8'hFF);
        chk("midreset_seg", seg4, 8'hFF);
        chk("midreset_fd", fd4, 1'b0);
        disp_valid = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        cyc = 0;
        chk("release_an0", an4, 8'hFF);
        step();
        chk("release_an1", an4, 8'hFE);
        chk("frame1_seg_d0", seg4, 8'hC0);

        // Load during frame 1; shadow only swaps at the cycle-31 boundary.
        step_to(5);
        pulse(32'h1234_5678);
        step_to(20);
        chk("frame1_an_d4", an4, 8'hEF);
        chk("frame1_seg_d4", seg4, 8'hC0);
        step_to(31);
        chk("fd_before", fd4, 1'b0);
        step_to(32);
        chk("fd_boundary", fd4, 1'b1);
        chk("frame1_seg_d7", seg4, 8'hC0);
        step_to(33);
        chk("fd_after", fd4, 1'b0);
        chk("frame2_an_d0", an4, 8'hFE);
        chk("frame2_seg_d0", seg4, 8'h80);
        step_to(37);
        chk("frame2_an_d1", an4, 8'hFD);
        chk("frame2_seg_d1", seg4, 8'hF8);

        // Two loads within frame 2: only the last one reaches frame 3.
        step_to(40);
        pulse(32'hAAAA_0000);
        step_to(42);
        chk("no_tear_d2", seg4, 8'h82);
        step_to(50);
        pulse(32'h0000_BBBB);
        step_to(61);
        chk("frame2_an_d7", an4, 8'h7F);
        chk("frame2_seg_d7", seg4, 8'hF9);
        step_to(65);
        chk("frame3_seg_d0", seg4, 8'h83);
        step_to(69);
        chk("frame3_seg_d1", seg4, 8'h83);
        step_to(81);
        chk("frame3_seg_d4", seg4, 8'hC0);
        // Load on the boundary cycle itself.
        step_to(95);
        pulse(32'h0000_000C);
        step_to(97);
        chk("boundary_load_d0", seg4, 8'hC6);

        // Leading-zero blanking with 0x00000A05, then with 0.
        step_to(100);
        pulse(32'h0000_0A05);
        step_to(128);
        lz_blank = 1'b1;
        step_to(129);
        chk("lz_d0", seg4, 8'h92);
        step_to(133);
        chk("lz_d1", seg4, 8'hC0);
        step_to(137);
        chk("lz_d2", seg4, 8'h88);
        step_to(140);
        pulse(32'h0000_0000);
        chk("lz_d3", seg4, 8'hFF);
        step_to(157);
        chk("lz_d7_seg", seg4, 8'hFF);
        chk("lz_d7_an", an4, 8'h7F);
        step_to(161);
        chk("lz_zero_d0", seg4, 8'hC0);
        step_to(165);
        chk("lz_zero_d1", seg4, 8'hFF);

        // Decimal points on digits 0 and 7.
        step_to(170);
        pulse(32'h8888_8888);
        step_to(189);
        chk("lz_zero_d7", seg4, 8'hFF);
        step_to(192);
        lz_blank = 1'b0;
        dp_mask  = 8'h81;
        step_to(193);
        chk("dp_d0", seg4, 8'h00);
        step_to(197);
        chk("dp_d1", seg4, 8'h80);
        step_to(209);
        chk("dp_d4", seg4, 8'h80);
        step_to(221);
        chk("dp_d7", seg4, 8'h00);

        // SCAN_DIV = 1: anode rotates every cycle, frame_done every 8 cycles.
        step_to(224);
        chk("div1_fd_a", fd1, 1'b1);
        step_to(225);
        chk("div1_an_d0", an1, 8'hFE);
        chk("div1_fd_off", fd1, 1'b0);
        step_to(226);
        chk("div1_an_d1", an1, 8'hFD);
        step_to(229);
        chk("div1_an_d4", an1, 8'hEF);
        step_to(232);
        chk("div1_an_d7", an1, 8'h7F);
        chk("div1_fd_b", fd1, 1'b1);
        step_to(233);
        chk("div1_an_wrap", an1, 8'hFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
